enable_period_checker: RTL and testbench

//  Receiving end of the clock-divider enable interface. Watches one periodic enable pulse

---
 rtl/enable_period_checker_if.sv | 26 ++
 rtl/enable_period_checker.sv | 118 +++++++++++
 tb/tb_enable_period_checker.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/enable_period_checker_if.sv
// Bundle of the per-line enable/pulse inputs and the checker status outputs.
// The master side drives the pulse train and control; the slave side is the checker.
interface enable_period_checker_if #(
  parameter int CNT_W = 16,
  parameter int ERR_W = 8
) ();
  logic             en;
  logic             en_in;
  logic             clr;
  logic             locked;
  logic             fault;
  logic             period_valid;
  logic [CNT_W-1:0] measured_period;
  logic [ERR_W-1:0] err_count;
  logic [1:0]       dbg_state;

  modport master (
    output en, en_in, clr,
    input  locked, fault, period_valid, measured_period, err_count, dbg_state
  );

  modport slave (
    input  en, en_in, clr,
    output locked, fault, period_valid, measured_period, err_count, dbg_state
  );
endinterface

// File: rtl/enable_period_checker.sv
// Measures the interval between pulses of one divider enable line, locks after a run
// of in-tolerance intervals and raises a sticky fault on a bad or missing pulse.
module enable_period_checker #(
  parameter int CNT_W           = 16,
  parameter int EXPECTED_PERIOD = 10,
  parameter int TOLERANCE       = 0,
  parameter int LOCK_COUNT      = 4,
  parameter int ERR_W           = 8
) (
  input logic                clk,
  input logic                rst,
  enable_period_checker_if.slave bus
);
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_MEASURE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;
  localparam logic [1:0] ST_FAULT   = 2'd3;

  localparam int GOOD_W = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT + 1) : 1;

  // Window bounds carry one extra bit so EXPECTED_PERIOD+TOLERANCE cannot wrap.
  localparam logic [CNT_W:0] HI_B = (CNT_W+1)'(EXPECTED_PERIOD + TOLERANCE);
  localparam logic [CNT_W:0] LO_B = (EXPECTED_PERIOD > TOLERANCE) ?
                                    (CNT_W+1)'(EXPECTED_PERIOD - TOLERANCE) : '0;
  localparam logic [CNT_W-1:0]  E_MAX     = '1;
  localparam logic [ERR_W-1:0]  ERR_MAX   = '1;
  localparam logic [GOOD_W-1:0] GOOD_LOCK = GOOD_W'(LOCK_COUNT);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  e_q, e_d;
  logic [GOOD_W-1:0] good_q, good_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [CNT_W-1:0]  mp_q, mp_d;
  logic              pv_q, pv_d;

  logic [CNT_W:0] e_ext;
  logic           ok;
  logic           timeout;

  assign e_ext   = {1'b0, e_q};
  assign ok      = (e_ext >= LO_B) && (e_ext <= HI_B);
  assign timeout = !bus.en_in && (e_ext >= HI_B);

  always_comb begin
    state_d = state_q;
    e_d     = e_q;
    good_d  = good_q;
    err_d   = err_q;
    mp_d    = mp_q;
    pv_d    = 1'b0;
    if (bus.en) begin
      e_d = bus.en_in ? CNT_W'(1) : ((e_q == E_MAX) ? e_q : e_q + 1'b1);
      // A pulse coincident with clr restarts measurement instead of being judged.
      if (bus.clr) begin
        state_d = bus.en_in ? ST_MEASURE : ST_IDLE;
        good_d  = '0;
      end else begin
        if (bus.en_in && (state_q != ST_IDLE)) begin
          pv_d = 1'b1;
          mp_d = e_q;
        end
        case (state_q)
          ST_IDLE: begin
            if (bus.en_in) begin
              state_d = ST_MEASURE;
              good_d  = '0;
            end
          end
          ST_MEASURE: begin
            if (bus.en_in && ok) begin
              if (good_q + 1'b1 == GOOD_LOCK) begin
                state_d = ST_LOCKED;
                good_d  = '0;
              end else begin
                good_d = good_q + 1'b1;
              end
            end else if (bus.en_in || timeout) begin
              good_d = '0;
            end
          end
          ST_LOCKED: begin
            if ((bus.en_in && !ok) || timeout) begin
              state_d = ST_FAULT;
              if (err_q != ERR_MAX) err_d = err_q + 1'b1;
            end
          end
          ST_FAULT: state_d = ST_FAULT;
          default:  state_d = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      e_q     <= '0;
      good_q  <= '0;
      err_q   <= '0;
      mp_q    <= '0;
      pv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      e_q     <= e_d;
      good_q  <= good_d;
      err_q   <= err_d;
      mp_q    <= mp_d;
      pv_q    <= pv_d;
    end
  end

  assign bus.locked          = (state_q == ST_LOCKED);
  assign bus.fault           = (state_q == ST_FAULT);
  assign bus.period_valid    = pv_q;
  assign bus.measured_period = mp_q;
  assign bus.err_count       = err_q;
  assign bus.dbg_state       = state_q;
endmodule

// File: tb/tb_enable_period_checker.sv
// Drives one pulse stream into a TOLERANCE=0 and a TOLERANCE=1 checker and compares
// both against an interval-arithmetic reference model through expected queues.
module tb_enable_period_checker;
  localparam int EXP  = 10;
  localparam int LOCK = 4;

  typedef enum int {M_IDLE, M_MEAS, M_LOCK, M_FAULT} mode_t;

  logic clk;
  logic rst_n;

  enable_period_checker_if #(.CNT_W(16), .ERR_W(8)) bus0 ();
  enable_period_checker_if #(.CNT_W(16), .ERR_W(8)) bus1 ();

  enable_period_checker #(.CNT_W(16), .EXPECTED_PERIOD(EXP), .TOLERANCE(0),
                          .LOCK_COUNT(LOCK), .ERR_W(8))
    dut0 (.clk(clk), .rst(rst_n), .bus(bus0));
  enable_period_checker #(.CNT_W(16), .EXPECTED_PERIOD(EXP), .TOLERANCE(1),
                          .LOCK_COUNT(LOCK), .ERR_W(8))
    dut1 (.clk(clk), .rst(rst_n), .bus(bus1));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state, one slot per instance
  int     tol_m[2] = '{0, 1};
  mode_t  mode_m[2];
  int     good_m[2];
  int     err_m[2];
  bit     pv_m[2];
  longint tick_m[2]   = '{0, 0};
  longint anchor_m[2] = '{0, 0};

  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];
  logic [21:0] st_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(string name, int inst, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] at %0t: got 0x%0h expected 0x%0h", name, inst, $time, act, exp);
    end
  endtask

  // Interval = active cycles since the last pulse (or since reset), capped at 2**16-1.
  task automatic model_step(int i, bit r, bit e, bit p, bit c);
    longint ival;
    int     lo, hi;
    bit     okv, tmo;
    pv_m[i] = 1'b0;
    if (!r) begin
      mode_m[i] = M_IDLE; good_m[i] = 0; err_m[i] = 0;
      anchor_m[i] = tick_m[i];
      return;
    end
    if (!e) return;
    ival = tick_m[i] - anchor_m[i];
    if (ival > 65535) ival = 65535;
    hi  = EXP + tol_m[i];
    lo  = (EXP - tol_m[i] < 0) ? 0 : EXP - tol_m[i];
    okv = p && (ival >= lo) && (ival <= hi);
    tmo = !p && (ival >= hi);
    if (p) anchor_m[i] = tick_m[i];
    tick_m[i]++;
    if (c) begin
      mode_m[i] = p ? M_MEAS : M_IDLE;
      good_m[i] = 0;
      return;
    end
    if (p && mode_m[i] != M_IDLE) begin
      pv_m[i] = 1'b1;
      if (i == 0) exp_q0.push_back(16'(ival));
      else        exp_q1.push_back(16'(ival));
    end
    case (mode_m[i])
      M_IDLE:  if (p) begin mode_m[i] = M_MEAS; good_m[i] = 0; end
      M_MEAS: begin
        if (okv) begin
          good_m[i]++;
          if (good_m[i] == LOCK) begin mode_m[i] = M_LOCK; good_m[i] = 0; end
        end else if (p || tmo) good_m[i] = 0;
      end
      M_LOCK: begin
        if ((p && !okv) || tmo) begin
          mode_m[i] = M_FAULT;
          if (err_m[i] < 255) err_m[i]++;
        end
      end
      default: ;
    endcase
  endtask

  // driver: one clock cycle of stimulus, expected post-edge status pushed
  task automatic cyc(bit r, bit e, bit p, bit c);
    rst_n = r;
    bus0.en = e; bus0.en_in = p; bus0.clr = c;
    bus1.en = e; bus1.en_in = p; bus1.clr = c;
    model_step(0, r, e, p, c);
    model_step(1, r, e, p, c);
    st_q.push_back({pv_m[0], mode_m[0] == M_LOCK, mode_m[0] == M_FAULT, 8'(err_m[0]),
                    pv_m[1], mode_m[1] == M_LOCK, mode_m[1] == M_FAULT, 8'(err_m[1])});
    @(negedge clk);
  endtask

  task automatic quiet(int n);
    for (int k = 0; k < n; k++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  // interval of n active cycles ending in a pulse; optional inactive cycles in between
  task automatic gap(int n, bit drops);
    for (int k = 1; k < n; k++) begin
      if (drops && $urandom_range(0, 3) == 0)
        for (int d = 0; d < $urandom_range(1, 4); d++)
          cyc(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
    end
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
  endtask

  // monitor / scoreboard
  initial begin
    logic [21:0] es;
    forever begin
      @(posedge clk);
      #1;
      if (st_q.size() != 0) begin
        es = st_q.pop_front();
        chk("status", 0, {bus0.period_valid, bus0.locked, bus0.fault, bus0.err_count}, es[21:11]);
        chk("status", 1, {bus1.period_valid, bus1.locked, bus1.fault, bus1.err_count}, es[10:0]);
        if (bus0.period_valid) begin
          if (exp_q0.size() == 0) chk("period_unexpected", 0, bus0.measured_period, 32'hFFFF_FFFF);
          else chk("period", 0, bus0.measured_period, exp_q0.pop_front());
        end
        if (bus1.period_valid) begin
          if (exp_q1.size() == 0) chk("period_unexpected", 1, bus1.measured_period, 32'hFFFF_FFFF);
          else chk("period", 1, bus1.measured_period, exp_q1.pop_front());
        end
        if (!rst_n || (es[21] == 1'b0 && es[20:11] == '0 && tick_m[0] == anchor_m[0])) begin
          if (!rst_n) begin
            chk("reset_period", 0, bus0.measured_period, 0);
            chk("reset_period", 1, bus1.measured_period, 0);
          end
        end
      end
    end
  end

  initial begin
    int op;
    // reset, then silence
    repeat (3) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    quiet(20);
    // lock on period-10 pulses, then interval 11
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    repeat (4) gap(10, 1'b0);
    gap(11, 1'b0);
    quiet(3);
    // clr with pulse, relock, then missing pulse
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    repeat (4) gap(10, 1'b0);
    quiet(12);
    // clr with pulse, relock, interval stretched by 5 disabled cycles
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    repeat (4) gap(10, 1'b0);
    quiet(4);
    repeat (5) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    quiet(5);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    gap(10, 1'b0);
    // tolerance window 9..11, then 12, then reset mid-interval
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    gap(9, 1'b0); gap(11, 1'b0); gap(10, 1'b0); gap(9, 1'b0);
    gap(12, 1'b0);
    quiet(4);
    repeat (2) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    quiet(5);
    // randomized traffic
    for (int it = 0; it < 300; it++) begin
      op = $urandom_range(0, 99);
      if (op < 70) begin
        case ($urandom_range(0, 6))
          0: gap(8, 1'b1);
          1: gap(9, 1'b1);
          2: gap(11, 1'b1);
          3: gap(12, 1'b1);
          default: gap(10, 1'b1);
        endcase
      end else if (op < 80) cyc(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'b1);
      else if (op < 85) for (int h = 0; h < $urandom_range(2, 3); h++) cyc(1'b1, 1'b1, 1'b1, 1'b0);
      else if (op < 90) quiet($urandom_range(11, 25));
      else if (op < 92) cyc(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else cyc(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    quiet(2);
    chk("leftover_periods", 0, exp_q0.size(), 0);
    chk("leftover_periods", 1, exp_q1.size(), 0);
    chk("leftover_status", 0, st_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
